// File: rtl/percept_pkg.sv
// Shared frame definitions for the perceptron link (transmitter and interface side).
package percept_pkg;

   localparam int   PERCEPT_ADDR_W    = 8;
   localparam logic PERCEPT_START_BIT = 1'b0;
   localparam logic PERCEPT_STOP_BIT  = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } percept_state_e;

endpackage

// File: rtl/percept_bit_timer.sv
// Bit-period timer: pulses tick on the last cycle of each CLKS_PER_BIT period.
module percept_bit_timer #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic restart,
   output logic tick
);

   localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt;

   // restart re-aligns the period to the accept edge, so no stale tick leaks in
   assign tick = en && !restart && (cnt == '0);

   // down-counter, reloads at the end of each bit period
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt <= LAST;
      end else if (en) begin
         cnt <= (cnt == '0) ? LAST : cnt - TW'(1);
      end
   end

endmodule

// File: rtl/percept_tx.sv
// Serial frame transmitter: start, address MSB-first, payload MSB-first,
// optional even parity (build with PERCEPT_TX_PARITY_EN), stop. Idle-high line.
module percept_tx
   import percept_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              send,
   input  logic [7:0]        address,
   input  logic [DATA_W-1:0] data,
   output logic              ready,
   output logic              done,
   output logic              serial_out
);

   localparam int SH_W   = PERCEPT_ADDR_W + DATA_W;
   localparam int CW_RAW = $clog2(DATA_W + 1);
   localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;
   localparam logic [CW-1:0] ADDR_LAST = CW'(PERCEPT_ADDR_W - 1);
   localparam logic [CW-1:0] DATA_LAST = CW'(DATA_W - 1);

   percept_state_e  state, state_n;
   logic [SH_W-1:0] sh, sh_n;
   logic [CW-1:0]   bcnt, bcnt_n;
   logic            ser_n, done_n, ready_n;
   logic            accept;
   logic            tick;
`ifdef PERCEPT_TX_PARITY_EN
   logic            par, par_n;
`endif

   percept_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .en      (state != ST_IDLE),
      .restart (accept),
      .tick    (tick)
   );

   // next-state / next-line-value: the line is computed one step ahead and registered
   always_comb begin
      state_n = state;
      sh_n    = sh;
      bcnt_n  = bcnt;
      ser_n   = serial_out;
      done_n  = 1'b0;
      accept  = 1'b0;
`ifdef PERCEPT_TX_PARITY_EN
      par_n   = par;
`endif
      case (state)
         ST_IDLE: begin
            ser_n = PERCEPT_STOP_BIT;
            if (send) begin
               accept  = 1'b1;
               state_n = ST_START;
               sh_n    = {address, data};
               ser_n   = PERCEPT_START_BIT;
`ifdef PERCEPT_TX_PARITY_EN
               par_n   = ^{address, data};
`endif
            end
         end
         ST_START: begin
            if (tick) begin
               state_n = ST_ADDR;
               bcnt_n  = ADDR_LAST;
               ser_n   = sh[SH_W-1];
               sh_n    = sh << 1;
            end
         end
         ST_ADDR: begin
            // the bit leaving on this tick is the next one in the shifter,
            // whether it is the next address bit or the first payload bit
            if (tick) begin
               ser_n = sh[SH_W-1];
               sh_n  = sh << 1;
               if (bcnt == '0) begin
                  state_n = ST_DATA;
                  bcnt_n  = DATA_LAST;
               end else begin
                  bcnt_n  = bcnt - CW'(1);
               end
            end
         end
         ST_DATA: begin
            if (tick) begin
               if (bcnt == '0) begin
`ifdef PERCEPT_TX_PARITY_EN
                  state_n = ST_PARITY;
                  ser_n   = par;
`else
                  state_n = ST_STOP;
                  ser_n   = PERCEPT_STOP_BIT;
`endif
               end else begin
                  ser_n  = sh[SH_W-1];
                  sh_n   = sh << 1;
                  bcnt_n = bcnt - CW'(1);
               end
            end
         end
`ifdef PERCEPT_TX_PARITY_EN
         ST_PARITY: begin
            if (tick) begin
               state_n = ST_STOP;
               ser_n   = PERCEPT_STOP_BIT;
            end
         end
`endif
         ST_STOP: begin
            if (tick) begin
               state_n = ST_IDLE;
               ser_n   = PERCEPT_STOP_BIT;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            ser_n   = PERCEPT_STOP_BIT;
         end
      endcase
      ready_n = (state_n == ST_IDLE);
   end

   // state and registered outputs; reset abandons any frame in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         sh         <= '0;
         bcnt       <= '0;
         serial_out <= PERCEPT_STOP_BIT;
         ready      <= 1'b1;
         done       <= 1'b0;
`ifdef PERCEPT_TX_PARITY_EN
         par        <= 1'b0;
`endif
      end else begin
         state      <= state_n;
         sh         <= sh_n;
         bcnt       <= bcnt_n;
         serial_out <= ser_n;
         ready      <= ready_n;
         done       <= done_n;
`ifdef PERCEPT_TX_PARITY_EN
         par        <= par_n;
`endif
      end
   end

endmodule

// File: tb/tb_percept_tx.sv
// Bench for percept_tx: two instances (CLKS_PER_BIT 1 and 4) share stimulus,
// each checked every cycle against a frame-queue model, plus literal pins.
module tb_percept_tx;

   localparam int DW = 8;
`ifdef PERCEPT_TX_PARITY_EN
   localparam int FB = 19;
   localparam logic [FB-1:0] LIT_A5_3C = 19'b0_10100101_00111100_0_1;
`else
   localparam int FB = 18;
   localparam logic [FB-1:0] LIT_A5_3C = 18'b0_10100101_00111100_1;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          send = 1'b0;
   logic [7:0]    address = '0;
   logic [DW-1:0] data = '0;
   logic [1:0]    ready_w, done_w, ser_w;

   int nvec = 0;
   int nerr = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   function automatic logic [FB-1:0] frame_bits(input logic [7:0] a, input logic [DW-1:0] d);
`ifdef PERCEPT_TX_PARITY_EN
      return {1'b0, a, d, ^{a, d}, 1'b1};
`else
      return {1'b0, a, d, 1'b1};
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   for (genvar g = 0; g < 2; g++) begin : g_inst
      localparam int CPB = (g == 0) ? 1 : 4;
      logic e_ser = 1'b1, e_rdy = 1'b1, e_done = 1'b0;
      logic [FB-1:0] fb;
      bit q[$];

      percept_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .send       (send),
         .address    (address),
         .data       (data),
         .ready      (ready_w[g]),
         .done       (done_w[g]),
         .serial_out (ser_w[g])
      );

      // model: a queue of per-cycle line values for the frame in flight
      always @(posedge clk) begin
         if (rst) begin
            q.delete();
            e_ser <= 1'b1; e_rdy <= 1'b1; e_done <= 1'b0;
         end else if (q.size() > 0) begin
            e_ser <= q.pop_front(); e_rdy <= 1'b0; e_done <= 1'b0;
         end else if (!e_rdy) begin
            e_ser <= 1'b1; e_rdy <= 1'b1; e_done <= 1'b1;
         end else begin
            e_done <= 1'b0;
            e_ser  <= 1'b1;
            if (send) begin
               fb = frame_bits(address, data);
               for (int i = FB - 1; i >= 0; i--)
                  for (int c = 0; c < CPB; c++) q.push_back(fb[i]);
               e_ser <= q.pop_front();
               e_rdy <= 1'b0;
            end
         end
      end

      always @(negedge clk) begin
         if (chk_en) begin
            check($sformatf("serial_out[cpb%0d]", CPB), 32'(ser_w[g]),   32'(e_ser));
            check($sformatf("ready[cpb%0d]", CPB),      32'(ready_w[g]), 32'(e_rdy));
            check($sformatf("done[cpb%0d]", CPB),       32'(done_w[g]),  32'(e_done));
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (ready_w !== 2'b11 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("wait_idle_timeout", 32'(ready_w), 32'h3);
   endtask

   // drive one request for one cycle; returns at the negedge right after the accept edge
   task automatic send_frame(input logic [7:0] a, input logic [DW-1:0] d);
      send = 1'b1; address = a; data = d;
      @(negedge clk);
      send = 1'b0;
   endtask

   // capture the CLKS_PER_BIT=1 line for one frame, then expect done
   task automatic capture1(output logic [FB-1:0] cap);
      for (int k = 0; k < FB; k++) begin
         cap[FB-1-k] = ser_w[0];
         @(negedge clk);
      end
      check("done_after_frame_cpb1", 32'(done_w[0]), 32'h1);
   endtask

   logic [FB-1:0] cap;
   int            dones;
   int            k4;

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      rst = 1'b0;

      // idle after reset
      repeat (20) @(negedge clk);
      check("idle_serial", 32'(ser_w),   32'h3);
      check("idle_ready",  32'(ready_w), 32'h3);
      check("idle_done",   32'(done_w),  32'h0);

      // model pins
      check("pin_frame_a5_3c", 32'(frame_bits(8'hA5, 8'h3C)), 32'(LIT_A5_3C));
`ifdef PERCEPT_TX_PARITY_EN
      check("pin_parity_01_00", 32'(frame_bits(8'h01, 8'h00)), 32'(19'b0_00000001_00000000_1_1));
`endif

      // basic frame at one clock per bit
      wait_idle();
      send_frame(8'hA5, 8'h3C);
      capture1(cap);
      check("line_a5_3c", 32'(cap), 32'(LIT_A5_3C));

      // four clocks per bit, send toggled mid-frame with other values
      wait_idle();
      send_frame(8'h80, 8'h01);
      k4 = -1;
      for (int k = 0; k < 400; k++) begin
         if (k == 3) check("cpb4_start_last", 32'(ser_w[1]), 32'h0);
         if (k == 4) check("cpb4_a7_first",   32'(ser_w[1]), 32'h1);
         if (k == 7) check("cpb4_a7_last",    32'(ser_w[1]), 32'h1);
         if (k == 8) check("cpb4_a6_first",   32'(ser_w[1]), 32'h0);
         if (done_w[1]) begin
            k4 = k;
            break;
         end
         if (k == 10) begin send = 1'b1; address = 8'hFF; data = 8'hFF; end
         if (k == 12) send = 1'b0;
         @(negedge clk);
      end
      check("cpb4_frame_len", 32'(k4), 32'(FB * 4));

`ifdef PERCEPT_TX_PARITY_EN
      wait_idle();
      send_frame(8'h01, 8'h00);
      capture1(cap);
      check("parity_01_00", 32'(cap[1]), 32'h1);
`endif

      // send held high: back-to-back frames with one idle cycle between
      wait_idle();
      send = 1'b1; address = 8'h5A; data = 8'hC3;
      dones = 0;
      for (int k = 0; k < 3 * (FB + 1); k++) begin
         @(negedge clk);
         if (done_w[0]) dones++;
      end
      send = 1'b0;
      check("b2b_done_count", 32'(dones), 32'h3);

      // reset in the address field, then a clean frame
      wait_idle();
      send_frame(8'hA5, 8'h3C);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_serial", 32'(ser_w),   32'h3);
      check("rst_mid_ready",  32'(ready_w), 32'h3);
      check("rst_mid_done",   32'(done_w),  32'h0);
      rst = 1'b0;
      @(negedge clk);
      send_frame(8'h3C, 8'hA5);
      capture1(cap);
      check("line_after_rst", 32'(cap), 32'(frame_bits(8'h3C, 8'hA5)));

      wait_idle();
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/percept_tx.md
# percept_tx

Serial frame transmitter for the perceptron link. Accepts an 8-bit target address and a DATA_W-bit payload over a ready/send handshake. Emits one frame on a single idle-high wire: start bit, address MSB first, payload MSB first, optional parity, stop bit. Sits on the host side of the link and drives the serial input of the perceptron interface, which matches the address.

## Interface
- `DATA_W`, default 8: payload bits per frame, minimum 1.
- `CLKS_PER_BIT`, default 1: clock cycles each serial bit is held, minimum 1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `send`  in  1  request to transmit; accepted only when `send && ready`.
- `address`  in  8  target address; sampled on accept.
- `data`  in  DATA_W  payload; sampled on accept.
- `ready`  out  1  high when idle and able to accept; reset value 1.
- `done`  out  1  one-cycle pulse after the final stop-bit cycle; reset value 0.
- `serial_out`  out  1  registered line output; idle and reset value 1.

## Operation
- States: IDLE, START, ADDR, DATA, PARITY, STOP.
- IDLE: `ready`=1 and `serial_out`=1. On accept, latch `address` and `data` into a shift register and go to START.
- START drives 0 for one bit period, then goes to ADDR.
- ADDR drives `address[7]` down to `address[0]`, 8 bit periods, then goes to DATA.
- DATA drives `data[DATA_W-1]` down to `data[0]`, DATA_W bit periods, then goes to PARITY (if enabled) or STOP.
- PARITY drives one bit period, then goes to STOP.
- STOP drives 1 for one bit period, then returns to IDLE with `done`=1 for one cycle.
- Bit counter width is clog2(DATA_W+1), at least 4 bits. It counts down and reloads per field. It does not wrap in a way visible on the line.
- `send` while `ready`=0 is ignored, not queued. Input changes after accept have no effect on the frame in flight.
- `rst` mid-frame abandons the frame: `serial_out`=1, `ready`=1, `done`=0 on the next edge, with no stop or parity bit emitted.

## Timing
- Accept at edge N means `serial_out` first drives 0 from edge N+1. `ready` drops at edge N+1.
- Each bit is stable for exactly CLKS_PER_BIT cycles.
- Frame length F = (10 + DATA_W [+1 parity]) × CLKS_PER_BIT cycles.
- `done` and `ready` both rise at edge N+1+F.
- Back-to-back: `send` held high in the `done` cycle is accepted. The next start bit follows the stop bit with exactly one idle-high cycle.
- `serial_out` comes from a flop, so there is no combinational path from any input.

## Configuration
- `PERCEPT_TX_PARITY_EN` defined: PARITY state is present. It sends an even-parity bit, the XOR of all 8 address bits and DATA_W payload bits, so total ones including parity is even. F includes the +1.
- Not defined: PARITY state and XOR logic are absent, and DATA goes directly to STOP.

## Structure
- The shared package `percept_pkg` holds:
  - the state encoding typedef;
  - `PERCEPT_ADDR_W`=8;
  - `PERCEPT_START_BIT`=0;
  - `PERCEPT_STOP_BIT`=1.
- The perceptron interface side uses the same constants, so both ends agree on the frame.
- One sub-module, `percept_bit_timer`:
  - a CLKS_PER_BIT down-counter with a `restart` input and a one-cycle `tick` output at bit-period end;
  - the FSM advances only on `tick`.

## Test plan
- Reset, then idle for 20 cycles: `serial_out`=1, `ready`=1, `done`=0 throughout.
- DATA_W=8, CLKS_PER_BIT=1, no parity, `address`=0xA5, `data`=0x3C: line carries 0,1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,1. `done` pulses 18 cycles after accept.
- CLKS_PER_BIT=4, `address`=0x80, `data`=0x01: each bit is held 4 cycles and the frame lasts 72 cycles. Toggling `send` mid-frame changes nothing.
- Parity enabled, `address`=0x01, `data`=0x00: parity bit=1. With `address`=0xA5, `data`=0x3C: parity bit=0. Frame is 19 bits.
- `send` held high continuously: consecutive frames are separated by exactly one idle-high cycle, and `done` pulses once per frame.
- `rst` asserted during the address field: next cycle `serial_out`=1, `ready`=1. A new accept afterwards transmits a complete, correct frame.
